fetch_buffer: RTL and testbench

Instruction fetch buffer sitting between the program counter / instruction memory (producer of fetched `pc`, `instr` pairs) and the decode stage (consumer). It queues up to DEPTH fetched words with valid/ready handshakes on both sides, computes the sequential PC+4 for each entry, and drops all queued work on a branch/jump redirect (`flush`). Misaligned fetch addresses are rejected and flagged, so decode never sees them.

---
 rtl/fetch_buffer.sv | 77 +++++++
 tb/tb_fetch_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: DEPTH-entry FWFT queue of {pc, instr} with flush and misalignment detection.
// Optional same-cycle bypass on an empty buffer when FETCH_BUF_BYPASS_EN is defined.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc_plus4,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   misalign_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            aligned, bypass, wr, pop;

  always_comb begin
    aligned  = (in_pc[1:0] == 2'b00);
`ifdef FETCH_BUF_BYPASS_EN
    bypass   = (count == '0) && !flush && in_valid && aligned;
`else
    bypass   = 1'b0;
`endif
    in_ready  = !flush && (count < FULL);
    out_valid = (!flush && (count != '0)) || bypass;
    head      = bypass ? '{pc: in_pc, instr: in_instr} : mem[rd_ptr];
    // A bypassed word taken by decode this cycle is never stored.
    wr  = in_valid && in_ready && aligned && !(bypass && out_ready);
    pop = out_valid && out_ready && !bypass;
  end

  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_pc_plus4 = head.pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (in_valid && in_ready && !aligned) misalign_err <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr) begin
          mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (wr && !pop)      count <= count + (AW+1)'(1);
        else if (!wr && pop) count <= count - (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus pushes expected words/status, a negedge monitor pops and compares.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0, misalign_err;
  logic [31:0] in_pc = '0, in_instr = '0, out_pc, out_instr, out_pc_plus4;
  logic [$clog2(DEPTH):0] count;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_pc_plus4(out_pc_plus4), .flush(flush), .count(count),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in_ready;
    logic out_valid;
    int   count;
    logic mis;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] exp_q[$];   // {pc, instr} in the order decode must see them
  int          mcnt = 0;
  logic        mis  = 1'b0;
  int          vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy plus an ordered list of stored words.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl);
    chk_t c;
    logic al, byp, acc, wr, pop;
    in_valid = v; in_pc = pc; in_instr = instr; out_ready = ordy; flush = fl;
    al  = (pc[1:0] == 2'b00);
    byp = BYP && (mcnt == 0) && !fl && v && al;
    c.in_ready  = !fl && (mcnt < DEPTH);
    c.out_valid = (!fl && mcnt != 0) || byp;
    c.count     = mcnt;
    c.mis       = mis;
    chk_q.push_back(c);
    acc = v && c.in_ready;
    if (acc && al) exp_q.push_back({pc, instr});
    wr  = acc && al && !(byp && ordy);
    pop = c.out_valid && ordy && !byp;
    if (acc && !al) mis = 1'b1;
    if (fl) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      mcnt = mcnt + (wr ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mcnt = 0; mis = 1'b0; exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (chk_q.size() > 0) begin
      chk_t c;
      logic [63:0] e;
      c = chk_q.pop_front();
      check("in_ready", 32'(in_ready), 32'(c.in_ready));
      check("out_valid", 32'(out_valid), 32'(c.out_valid));
      check("count", 32'(count), c.count);
      check("misalign_err", 32'(misalign_err), 32'(c.mis));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pop_empty: got pc %h with no word expected", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e[63:32]);
          check("out_instr", out_instr, e[31:0]);
          check("out_pc_plus4", out_pc_plus4, e[63:32] + 32'd4);
        end
      end
    end
  end

  initial begin
    do_reset();
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc_plus4", out_pc_plus4, 32'h4);

    // fill to full, then drain in order
    for (int k = 0; k < 4; k++) step(1'b1, 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'hDEAD, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // continuous stream, pointers wrap
    for (int k = 0; k < 20; k++) step(1'b1, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush with a concurrent offer: 0x40 must never appear
    for (int k = 0; k < 3; k++) step(1'b1, 32'h200 + 32'(4 * k), 32'hC000_0000 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h40, 32'h4040, 1'b1, 1'b1);
    step(1'b1, 32'h300, 32'h3030, 1'b0, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // misaligned offer: sticky through flush
    step(1'b1, 32'h102, 32'h1111, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h104, 32'h2222, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // PC+4 wraps
    step(1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // empty buffer, ready decode: same-cycle with bypass, next cycle without
    step(1'b1, 32'h20, 32'h2020, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc;
      pc = $urandom();
      if ($urandom_range(0, 31) != 0) pc = pc & 32'hFFFF_FFFC;
      step(1'($urandom_range(0, 1)), pc, $urandom(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    // reset mid-operation drops entries and clears the sticky error
    step(1'b1, 32'h502, 32'h5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h600 + 32'(4 * k), 32'h6, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 32'h700, 32'h7777, 1'b0, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
